dump_axis_collector: RTL and testbench

DUMP_AXIS_COLLECTOR -- requirements
Module: dump_axis_collector

---
 rtl/MD_pkg.sv | 15 +
 rtl/dump_axis_collector_if.sv | 34 +++
 rtl/dump_sync_fifo.sv | 50 +++++
 rtl/dump_axis_collector.sv | 153 +++++++++++++++
 tb/tb_dump_axis_collector.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/MD_pkg.sv
// Shared widths and FSM state type for the dump/AXI-stream collector.
package MD_pkg;

  localparam int unsigned AXIS_TDATA_WIDTH = 512;
  localparam int unsigned TDEST_WIDTH      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLocal,
    StRemote,
    StFlush,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dump_axis_collector_if.sv
// Network force stream (s) and host stream (m) of the dump collector.
interface dump_axis_collector_if;
  import MD_pkg::*;

  logic                              s_axis_n2k_frc_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0]       s_axis_n2k_frc_tdata;
  logic                              s_axis_n2k_frc_tlast;
  logic                              s_axis_n2k_frc_tready;

  logic                              m_axis_k2h_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0]       m_axis_k2h_tdata;
  logic [AXIS_TDATA_WIDTH/8-1:0]     m_axis_k2h_tkeep;
  logic                              m_axis_k2h_tlast;
  logic [TDEST_WIDTH-1:0]            m_axis_k2h_tdest;
  logic                              m_axis_k2h_tready;

  // Collector side: consumes the network stream, produces the host stream.
  modport master (
    input  s_axis_n2k_frc_tvalid, s_axis_n2k_frc_tdata, s_axis_n2k_frc_tlast,
    output s_axis_n2k_frc_tready,
    output m_axis_k2h_tvalid, m_axis_k2h_tdata, m_axis_k2h_tkeep, m_axis_k2h_tlast,
    output m_axis_k2h_tdest,
    input  m_axis_k2h_tready
  );

  modport slave (
    output s_axis_n2k_frc_tvalid, s_axis_n2k_frc_tdata, s_axis_n2k_frc_tlast,
    input  s_axis_n2k_frc_tready,
    input  m_axis_k2h_tvalid, m_axis_k2h_tdata, m_axis_k2h_tkeep, m_axis_k2h_tlast,
    input  m_axis_k2h_tdest,
    output m_axis_k2h_tready
  );

endinterface

// File: rtl/dump_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module dump_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == FULL_C);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dump_axis_collector.sv
// Streams local cache records then remote network records to the host.
// Optional DUMP_CHECK_EN adds a sticky o_err for network protocol faults.
module dump_axis_collector
  import MD_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_dump_start,
  input  logic [15:0]                 i_dump_ID,
  input  logic [15:0]                 i_num_local,
  input  logic [15:0]                 i_num_remote,
  output logic                        o_rd_en,
  output logic [ADDR_W-1:0]           o_rd_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_rd_data,
  dump_axis_collector_if.master       io_axis,
  output logic                        o_dump_busy,
  output logic                        o_dump_done
`ifdef DUMP_CHECK_EN
  ,
  output logic                        o_err
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  dump_state_e                 r_state, w_state_nxt;
  logic [15:0]                 r_num_local, r_num_remote, r_rd_cnt, r_rem_cnt;
  logic [16:0]                 r_total, r_out_cnt;
  logic [TDEST_WIDTH-1:0]      r_dest;
  logic [ADDR_W-1:0]           r_rd_addr;
  logic                        r_rd_inflight;
  logic                        w_start, w_credit, w_rd_en, w_last_rd;
  logic                        w_net_rdy, w_net_acc, w_last_rem, w_flush_done;
  logic                        w_push, w_pop, w_full, w_empty, w_unused;
  logic [CNT_W-1:0]            w_count;
  logic [AXIS_TDATA_WIDTH-1:0] w_push_data, w_head;

  assign w_start   = (r_state == StIdle) && i_dump_start;
  // A read issued now lands one cycle later; count it against the FIFO until then.
  assign w_credit  = ({1'b0, w_count} + {{CNT_W{1'b0}}, r_rd_inflight}) < DEPTH_C;
  assign w_rd_en   = (r_state == StLocal) && w_credit;
  assign w_last_rd = w_rd_en && (r_rd_cnt == r_num_local - 16'd1);

  // The final local read lands on the first REMOTE cycle; keep that push slot free.
  assign w_net_rdy  = (r_state == StRemote) && !w_full && !r_rd_inflight;
  assign w_net_acc  = w_net_rdy && io_axis.s_axis_n2k_frc_tvalid;
  assign w_last_rem = w_net_acc && (r_rem_cnt == r_num_remote - 16'd1);

  assign w_push       = r_rd_inflight || w_net_acc;
  assign w_push_data  = r_rd_inflight ? i_rd_data : io_axis.s_axis_n2k_frc_tdata;
  assign w_pop        = !w_empty && io_axis.m_axis_k2h_tready;
  assign w_flush_done = w_empty && (r_out_cnt == r_total);
  assign w_unused     = ^{i_dump_ID[15:TDEST_WIDTH], io_axis.s_axis_n2k_frc_tlast};

  dump_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_dump_start) begin
          if (i_num_local != 16'd0)       w_state_nxt = StLocal;
          else if (i_num_remote != 16'd0) w_state_nxt = StRemote;
          else                            w_state_nxt = StDone;
        end
      end
      StLocal:  if (w_last_rd) w_state_nxt = (r_num_remote != 16'd0) ? StRemote : StFlush;
      StRemote: if (w_last_rem) w_state_nxt = StFlush;
      StFlush:  if (w_flush_done) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_num_local   <= '0;
      r_num_remote  <= '0;
      r_total       <= '0;
      r_dest        <= '0;
      r_rd_cnt      <= '0;
      r_rd_addr     <= '0;
      r_rem_cnt     <= '0;
      r_out_cnt     <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_inflight <= w_rd_en;
      if (w_start) begin
        r_num_local  <= i_num_local;
        r_num_remote <= i_num_remote;
        r_total      <= {1'b0, i_num_local} + {1'b0, i_num_remote};
        r_dest       <= i_dump_ID[TDEST_WIDTH-1:0];
        r_rd_cnt     <= '0;
        r_rd_addr    <= '0;
        r_rem_cnt    <= '0;
        r_out_cnt    <= '0;
      end else begin
        if (w_rd_en) begin
          r_rd_cnt  <= r_rd_cnt + 16'd1;
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
        if (w_net_acc) r_rem_cnt <= r_rem_cnt + 16'd1;
        if (w_pop)     r_out_cnt <= r_out_cnt + 17'd1;
      end
    end
  end

  assign o_rd_en   = w_rd_en;
  assign o_rd_addr = r_rd_addr;
  assign io_axis.s_axis_n2k_frc_tready = w_net_rdy;
  assign io_axis.m_axis_k2h_tvalid = !w_empty;
  assign io_axis.m_axis_k2h_tdata  = w_empty ? '0 : w_head;
  assign io_axis.m_axis_k2h_tkeep  = w_empty ? '0 : '1;
  assign io_axis.m_axis_k2h_tlast  = !w_empty && ((r_out_cnt + 17'd1) == r_total);
  assign io_axis.m_axis_k2h_tdest  = r_dest;
  assign o_dump_busy = (r_state == StLocal) || (r_state == StRemote) || (r_state == StFlush);
  assign o_dump_done = (r_state == StDone);

`ifdef DUMP_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_net_acc && io_axis.s_axis_n2k_frc_tlast && !w_last_rem) ||
                 ((r_state == StIdle) && io_axis.s_axis_n2k_frc_tvalid)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`endif

endmodule

// File: tb/tb_dump_axis_collector.sv
// Directed bench for dump_axis_collector: ordering, back-pressure, reset and edge cases.
module tb_dump_axis_collector;
  import MD_pkg::*;

  localparam int unsigned ADDR_W = 9;

  typedef struct {
    logic [AXIS_TDATA_WIDTH-1:0] data;
    logic                        last;
    logic [TDEST_WIDTH-1:0]      dest;
    int                          cyc;
  } beat_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        i_dump_start;
  logic [15:0]                 i_dump_ID, i_num_local, i_num_remote;
  logic                        o_rd_en;
  logic [ADDR_W-1:0]           o_rd_addr;
  logic [AXIS_TDATA_WIDTH-1:0] i_rd_data;
  logic                        o_dump_busy, o_dump_done;
`ifdef DUMP_CHECK_EN
  logic                        o_err;
`endif

  dump_axis_collector_if axis ();

  dump_axis_collector #(
    .FIFO_DEPTH (16),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_dump_start (i_dump_start),
    .i_dump_ID    (i_dump_ID),
    .i_num_local  (i_num_local),
    .i_num_remote (i_num_remote),
    .o_rd_en      (o_rd_en),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .io_axis      (axis.master),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
`ifdef DUMP_CHECK_EN
    ,
    .o_err        (o_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  beat_t       host_q[$];
  logic [ADDR_W-1:0] rd_q[$];

  function automatic logic [AXIS_TDATA_WIDTH-1:0] local_word(input int a);
    return AXIS_TDATA_WIDTH'(32'hA000_0000) + AXIS_TDATA_WIDTH'(a);
  endfunction

  function automatic logic [AXIS_TDATA_WIDTH-1:0] remote_word(input int k);
    return AXIS_TDATA_WIDTH'(32'hB000_0000) + AXIS_TDATA_WIDTH'(k);
  endfunction

  // Cache model: one-cycle read latency
  logic [AXIS_TDATA_WIDTH-1:0] rd_data_q = '0;
  always @(posedge clk) if (o_rd_en) rd_data_q <= local_word(int'(o_rd_addr));
  assign i_rd_data = rd_data_q;

  // Monitor sampled mid-cycle: records issued reads and accepted host beats
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (axis.m_axis_k2h_tvalid && axis.m_axis_k2h_tready)
        host_q.push_back('{axis.m_axis_k2h_tdata, axis.m_axis_k2h_tlast,
                           axis.m_axis_k2h_tdest, cyc});
      if (o_rd_en) rd_q.push_back(o_rd_addr);
    end
  end

  task automatic chk(input string tag, input logic [AXIS_TDATA_WIDTH-1:0] obs,
                     input logic [AXIS_TDATA_WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_dump(input logic [15:0] id, input logic [15:0] nl,
                            input logic [15:0] nr);
    @(posedge clk); #1;
    i_dump_ID = id; i_num_local = nl; i_num_remote = nr; i_dump_start = 1'b1;
    @(posedge clk); #1;
    i_dump_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_dump_done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, AXIS_TDATA_WIDTH'(seen), AXIS_TDATA_WIDTH'(1));
    @(negedge clk);
    chk({tag, "_done_single"}, AXIS_TDATA_WIDTH'(o_dump_done), '0);
    chk({tag, "_busy_after"}, AXIS_TDATA_WIDTH'(o_dump_busy), '0);
  endtask

  task automatic send_net(input int n, input int last_idx);
    for (int k = 0; k < n; k++) begin
      logic ok = 1'b0;
      axis.s_axis_n2k_frc_tvalid = 1'b1;
      axis.s_axis_n2k_frc_tdata  = remote_word(k);
      axis.s_axis_n2k_frc_tlast  = (k == last_idx);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (axis.s_axis_n2k_frc_tready) begin ok = 1'b1; break; end
      end
      chk($sformatf("net_ready[%0d]", k), AXIS_TDATA_WIDTH'(ok), AXIS_TDATA_WIDTH'(1));
      @(posedge clk); #1;
    end
    axis.s_axis_n2k_frc_tvalid = 1'b0;
    axis.s_axis_n2k_frc_tlast  = 1'b0;
  endtask

  task automatic check_reads(input string tag, input int n);
    chk({tag, "_rd_count"}, AXIS_TDATA_WIDTH'(rd_q.size()), AXIS_TDATA_WIDTH'(n));
    for (int i = 0; i < n; i++)
      if (i < rd_q.size())
        chk($sformatf("%s_rd_addr[%0d]", tag, i), AXIS_TDATA_WIDTH'(rd_q[i]),
            AXIS_TDATA_WIDTH'(i));
  endtask

  task automatic check_host(input string tag, input int nl, input int nr,
                            input logic [TDEST_WIDTH-1:0] dest);
    int n = nl + nr;
    chk({tag, "_beats"}, AXIS_TDATA_WIDTH'(host_q.size()), AXIS_TDATA_WIDTH'(n));
    for (int i = 0; i < n; i++) begin
      if (i < host_q.size()) begin
        chk($sformatf("%s_data[%0d]", tag, i), host_q[i].data,
            (i < nl) ? local_word(i) : remote_word(i - nl));
        chk($sformatf("%s_last[%0d]", tag, i), AXIS_TDATA_WIDTH'(host_q[i].last),
            AXIS_TDATA_WIDTH'(i == n - 1));
        chk($sformatf("%s_dest[%0d]", tag, i), AXIS_TDATA_WIDTH'(host_q[i].dest),
            AXIS_TDATA_WIDTH'(dest));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"},   AXIS_TDATA_WIDTH'(o_rd_en), '0);
    chk({tag, "_rd_addr"}, AXIS_TDATA_WIDTH'(o_rd_addr), '0);
    chk({tag, "_tvalid"},  AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tvalid), '0);
    chk({tag, "_tdata"},   axis.m_axis_k2h_tdata, '0);
    chk({tag, "_tkeep"},   AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tkeep), '0);
    chk({tag, "_tlast"},   AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tlast), '0);
    chk({tag, "_tdest"},   AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tdest), '0);
    chk({tag, "_tready"},  AXIS_TDATA_WIDTH'(axis.s_axis_n2k_frc_tready), '0);
    chk({tag, "_busy"},    AXIS_TDATA_WIDTH'(o_dump_busy), '0);
    chk({tag, "_done"},    AXIS_TDATA_WIDTH'(o_dump_done), '0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_dump_start = 1'b0; i_dump_ID = '0; i_num_local = '0; i_num_remote = '0;
    axis.s_axis_n2k_frc_tvalid = 1'b0; axis.s_axis_n2k_frc_tdata = '0;
    axis.s_axis_n2k_frc_tlast = 1'b0; axis.m_axis_k2h_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
`ifdef DUMP_CHECK_EN
    chk("reset_err", AXIS_TDATA_WIDTH'(o_err), '0);
`endif
    @(posedge clk); #1; rst = 1'b0;

    // Four local records, no remote, host always ready
    axis.m_axis_k2h_tready = 1'b1;
    host_q.delete(); rd_q.delete();
    start_dump(16'h1235, 16'd4, 16'd0);
    @(negedge clk);
    chk("a_busy_during", AXIS_TDATA_WIDTH'(o_dump_busy), AXIS_TDATA_WIDTH'(1));
    wait_done("a", 100);
    check_reads("a", 4);
    check_host("a", 4, 0, 4'h5);
    if (host_q.size() == 4)
      chk("a_throughput", AXIS_TDATA_WIDTH'(host_q[3].cyc - host_q[0].cyc),
          AXIS_TDATA_WIDTH'(3));

    // Two local then three remote records
    host_q.delete(); rd_q.delete();
    start_dump(16'hBEE7, 16'd2, 16'd3);
    send_net(3, 2);
    wait_done("b", 100);
    check_reads("b", 2);
    check_host("b", 2, 3, 4'h7);

    // Host stalled for 30 cycles with 40 local records pending
    axis.m_axis_k2h_tready = 1'b0;
    host_q.delete(); rd_q.delete();
    start_dump(16'h0003, 16'd40, 16'd0);
    repeat (30) @(negedge clk);
    chk("c_reads_stalled", AXIS_TDATA_WIDTH'(rd_q.size()), AXIS_TDATA_WIDTH'(16));
    chk("c_rd_en_low", AXIS_TDATA_WIDTH'(o_rd_en), '0);
    chk("c_rd_addr", AXIS_TDATA_WIDTH'(o_rd_addr), AXIS_TDATA_WIDTH'(16));
    chk("c_tvalid", AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tvalid), AXIS_TDATA_WIDTH'(1));
    chk("c_no_beats", AXIS_TDATA_WIDTH'(host_q.size()), '0);
    @(posedge clk); #1; axis.m_axis_k2h_tready = 1'b1;
    wait_done("c", 400);
    check_reads("c", 40);
    check_host("c", 40, 0, 4'h3);

    // Empty dump
    host_q.delete(); rd_q.delete();
    start_dump(16'h0009, 16'd0, 16'd0);
    @(negedge clk);
    chk("d_done_pulse", AXIS_TDATA_WIDTH'(o_dump_done), AXIS_TDATA_WIDTH'(1));
    chk("d_busy", AXIS_TDATA_WIDTH'(o_dump_busy), '0);
    @(negedge clk);
    chk("d_done_gone", AXIS_TDATA_WIDTH'(o_dump_done), '0);
    repeat (3) @(negedge clk);
    chk("d_beats", AXIS_TDATA_WIDTH'(host_q.size()), '0);
    chk("d_reads", AXIS_TDATA_WIDTH'(rd_q.size()), '0);

    // Reset in the middle of a local phase with the FIFO half full
    axis.m_axis_k2h_tready = 1'b0;
    start_dump(16'h00A1, 16'd20, 16'd0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs_zero("e_rst");
    @(posedge clk); #1; rst = 1'b0;
    axis.m_axis_k2h_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("e_idle_tvalid", AXIS_TDATA_WIDTH'(axis.m_axis_k2h_tvalid), '0);
    host_q.delete(); rd_q.delete();
    start_dump(16'h0042, 16'd3, 16'd0);
    wait_done("e", 100);
    check_reads("e", 3);
    check_host("e", 3, 0, 4'h2);

`ifdef DUMP_CHECK_EN
    // Network tlast on the second of three remote beats
    host_q.delete(); rd_q.delete();
    chk("f_err_clear", AXIS_TDATA_WIDTH'(o_err), '0);
    start_dump(16'h0001, 16'd0, 16'd3);
    send_net(3, 1);
    wait_done("f", 100);
    chk("f_err_set", AXIS_TDATA_WIDTH'(o_err), AXIS_TDATA_WIDTH'(1));
    repeat (5) @(negedge clk);
    chk("f_err_sticky", AXIS_TDATA_WIDTH'(o_err), AXIS_TDATA_WIDTH'(1));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("f_err_reset", AXIS_TDATA_WIDTH'(o_err), '0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
